hazard_scoreboard: RTL
======================

# hazard_scoreboard

Parametrised pipeline hazard controller for the 5-stage datapath, replacing the fixed load-use/mispredict logic. It tracks pending register writes from variable-latency producers with per-register countdown counters, and stalls ID only as long as a true RAW dependency needs. It also sequences redirect flushes, cache-wait freezes and a halt-drain state machine, and keeps stall/flush performance counters. It drives the pipeline-register enables/flushes and `pcen`.

## Interface
- `NREGS`, 32, architectural register count; register 0 never tracked
- `REGW`, $clog2(NREGS), register index width
- `MAXLAT`, 4, max producer latency in cycles (ALU=1, load=2)
- `LATW`, $clog2(MAXLAT+1), width of `ex_lat` and per-register counters
- `DRAIN`, 2, cycles to let MEM/WB retire after halt is seen
- `CLK`  in  1  clock, all state on rising edge
- `RST`  in  1  reset, synchronous, active-high
- `id_valid`, `id_rs`, `id_rt`  in  1/REGW/REGW  decode-stage sources
- `ex_valid`, `ex_regwen`, `ex_rd`, `ex_lat`  in  1/1/REGW/LATW  EX-stage producer
- `mem_redirect`  in  1  branch mispredict or jump/jr resolved in MEM
- `halt`  in  1  halt instruction in MEM
- `imem_wait`, `dmem_wait`  in  1  cache not ready
- `pcen`, `if_id_en`, `id_ex_en`, `ex_mem_en`, `mem_wb_en`  out  1  stage advance
- `if_id_flush`, `id_ex_flush`, `ex_mem_flush`  out  1  bubble insert
- `halted`  out  1  pipeline fully drained after halt
- `stall_cnt`, `flush_cnt`  out  32  performance counters

## Operation
- State: `cnt[NREGS]` (LATW each), FSM {RUN, DRAIN_S, HALTED}, drain counter, two perf counters.
- Effective latency L = clamp(`ex_lat`, 1, MAXLAT). A consumer needs L-1 stall cycles behind a producer.
- RAW stall: `id_valid` and, for s in {rs, rt} with s≠0:
  - `cnt[s]`≠0, or
  - (`ex_valid`&`ex_regwen`&`ex_rd`==s&L≥2).
- Scoreboard load, when `ex_mem_en`&~`ex_mem_flush`&`ex_valid`&`ex_regwen`&`ex_rd`≠0: `cnt[ex_rd]` ← max(`cnt[ex_rd]`-1 sat 0, L-2).
- Every other non-frozen cycle: all nonzero counters decrement by 1.
- Frozen cycle (`dmem_wait`): counters hold.
- Output priority, highest first; defaults are all enables 1, flushes 0, `pcen` 1:
  1. `RST`: `pcen`=0, all enables 1, all flushes 1.
  2. HALTED: all enables 0, `pcen`=0, flushes 0, `halted`=1.
  3. `dmem_wait`: all enables 0, `pcen`=0, flushes 0.
  4. `halt` in RUN, or state DRAIN_S: `pcen`=0, `if_id_flush`=`id_ex_flush`=`ex_mem_flush`=1; MEM/WB advance.
  5. `mem_redirect`: `pcen`=1, `if_id_flush`=`id_ex_flush`=`ex_mem_flush`=1. Overrides RAW stall and `imem_wait`.
  6. RAW stall: `pcen`=0, `if_id_en`=0, `id_ex_flush`=1.
  7. `imem_wait`: `pcen`=0, `if_id_flush`=1.
- FSM transitions:
  - RUN→DRAIN_S on `halt`&~`dmem_wait`; loads drain counter with DRAIN-1.
  - DRAIN_S decrements on non-frozen cycles; →HALTED when it is 0.
  - HALTED holds until `RST`.
- `stall_cnt` +1 per cycle where rule 6 is the active rule.
- `flush_cnt` +1 per cycle where rule 5 is active. Both wrap mod 2^32 and are frozen in HALTED.

## Timing
- Reset values: `cnt`=0, FSM RUN, drain counter 0, `stall_cnt`=`flush_cnt`=0, `halted`=0.
- All control outputs are combinational from inputs and current state; no added latency.
- Load (L=2) then dependent consumer: exactly 1 bubble. L=4: exactly 3 bubbles.
- Independent instructions: 0 bubbles.
- Redirect and RAW stall in the same cycle: redirect wins; the stalled consumer is flushed; no stall counted.
- A producer flushed in EX by a redirect does not load the scoreboard.
- `dmem_wait` during redirect: redirect deferred until unfrozen (MEM held).
- `halt` and `mem_redirect` in the same cycle: halt wins; `flush_cnt` unchanged.
- `RST` mid-stall or mid-drain: next cycle RUN, counters cleared.

## Test plan
- Load r5 (ex_lat=2) in EX, ID reads rs=5 → one cycle `pcen`=0,`if_id_en`=0,`id_ex_flush`=1; `stall_cnt`=1.
- ex_lat=4 writes r3, consumer rt=3 → 3 consecutive stall cycles. Insert `dmem_wait` for 2 cycles mid-sequence → stall still totals 3 unfrozen cycles.
- Producer writes r0 with ex_lat=4, consumer rs=0 → no stall. Consumer of r7 behind an ALU (L=1) → no stall.
- `mem_redirect` while RAW stall pending → `pcen`=1, three flushes=1, `flush_cnt`=1, `stall_cnt` unchanged. Flushed EX load does not stall the next instruction.
- `halt` with DRAIN=2 → 2 cycles `pcen`=0 with MEM/WB enabled, then `halted`=1 and all enables 0. `RST` → `halted`=0, counters 0.

Source files
------------

// File: rtl/hazard_scoreboard_if.sv
// Purpose: bundles the decode/EX/MEM hazard inputs and the pipeline-control
//   outputs exchanged between the 5-stage datapath and hazard_scoreboard.
// Ports: master = datapath side (drives hazard inputs, sees controls);
//   slave = hazard_scoreboard side (sees hazard inputs, drives controls).
interface hazard_scoreboard_if #(
  parameter int NREGS  = 32,
  parameter int MAXLAT = 4
);
  localparam int REGW = $clog2(NREGS);
  localparam int LATW = $clog2(MAXLAT + 1);

  // Decode-stage consumer
  logic            id_valid;
  logic [REGW-1:0] id_rs;
  logic [REGW-1:0] id_rt;
  // EX-stage producer
  logic            ex_valid;
  logic            ex_regwen;
  logic [REGW-1:0] ex_rd;
  logic [LATW-1:0] ex_lat;
  // MEM-stage events and memory stalls
  logic            mem_redirect;
  logic            halt;
  logic            imem_wait;
  logic            dmem_wait;
  // Pipeline controls
  logic            pcen;
  logic            if_id_en;
  logic            id_ex_en;
  logic            ex_mem_en;
  logic            mem_wb_en;
  logic            if_id_flush;
  logic            id_ex_flush;
  logic            ex_mem_flush;
  logic            halted;
  logic [31:0]     stall_cnt;
  logic [31:0]     flush_cnt;

  modport master (
    output id_valid, id_rs, id_rt, ex_valid, ex_regwen, ex_rd, ex_lat,
           mem_redirect, halt, imem_wait, dmem_wait,
    input  pcen, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
           if_id_flush, id_ex_flush, ex_mem_flush, halted, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_valid, id_rs, id_rt, ex_valid, ex_regwen, ex_rd, ex_lat,
           mem_redirect, halt, imem_wait, dmem_wait,
    output pcen, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
           if_id_flush, id_ex_flush, ex_mem_flush, halted, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Purpose: pipeline hazard controller; per-register countdown scoreboard for
//   variable-latency producers, redirect flush, cache freeze, halt drain, perf counters.
// Latency: all controls combinational from inputs and current state (0 cycles).
// Backpressure: dmem_wait freezes every stage and the scoreboard; imem_wait and
//   RAW stalls hold the front end only.
// Ports: clk_i, rst_i (sync, active-high); sb_if (slave modport) carries the
//   decode/EX/MEM hazard inputs and the enable/flush/pcen/halted/counter outputs.
module hazard_scoreboard #(
  parameter int NREGS  = 32,
  parameter int MAXLAT = 4,
  parameter int DRAIN  = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  hazard_scoreboard_if.slave    sb_if
);
  localparam int REGW = $clog2(NREGS);
  localparam int LATW = $clog2(MAXLAT + 1);
  localparam int DW   = (DRAIN > 1) ? $clog2(DRAIN) : 1;

  typedef enum logic [1:0] {RUN, DRAIN_S, HALTED} state_t;

  state_t          state_q, state_d;
  logic [DW-1:0]   drain_q, drain_d;
  logic [LATW-1:0] cnt_q [NREGS];
  logic [LATW-1:0] cnt_d [NREGS];
  logic [31:0]     stall_q, stall_d;
  logic [31:0]     flush_q, flush_d;

  logic [LATW-1:0] lat_eff;
  logic            ex_wr;
  logic            haz_rs, haz_rt, raw_stall;
  logic            rule_redir, rule_stall;
  logic            sb_load;

  logic pcen, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic if_id_flush, id_ex_flush, ex_mem_flush, halted;

  // Effective producer latency, clamped into [1, MAXLAT].
  always_comb begin
    if (sb_if.ex_lat == '0)
      lat_eff = LATW'(1);
    else if (sb_if.ex_lat > LATW'(MAXLAT))
      lat_eff = LATW'(MAXLAT);
    else
      lat_eff = sb_if.ex_lat;
  end

  // A source is hazardous while its counter runs, or when the producer sitting
  // in EX right now needs at least one bubble (L>=2). r0 is never a hazard.
  always_comb begin
    ex_wr     = sb_if.ex_valid & sb_if.ex_regwen;
    haz_rs    = (sb_if.id_rs != '0) &&
                ((cnt_q[sb_if.id_rs] != '0) ||
                 (ex_wr && (sb_if.ex_rd == sb_if.id_rs) && (lat_eff >= LATW'(2))));
    haz_rt    = (sb_if.id_rt != '0) &&
                ((cnt_q[sb_if.id_rt] != '0) ||
                 (ex_wr && (sb_if.ex_rd == sb_if.id_rt) && (lat_eff >= LATW'(2))));
    raw_stall = sb_if.id_valid & (haz_rs | haz_rt);
  end

  // Control outputs in strict priority order, plus FSM next state.
  always_comb begin
    pcen         = 1'b1;
    if_id_en     = 1'b1;
    id_ex_en     = 1'b1;
    ex_mem_en    = 1'b1;
    mem_wb_en    = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    halted       = 1'b0;
    rule_redir   = 1'b0;
    rule_stall   = 1'b0;
    state_d      = state_q;
    drain_d      = drain_q;

    if (rst_i) begin
      pcen         = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      ex_mem_flush = 1'b1;
    end else if (state_q == HALTED) begin
      pcen      = 1'b0;
      if_id_en  = 1'b0;
      id_ex_en  = 1'b0;
      ex_mem_en = 1'b0;
      mem_wb_en = 1'b0;
      halted    = 1'b1;
    end else if (sb_if.dmem_wait) begin
      pcen      = 1'b0;
      if_id_en  = 1'b0;
      id_ex_en  = 1'b0;
      ex_mem_en = 1'b0;
      mem_wb_en = 1'b0;
    end else if ((sb_if.halt && state_q == RUN) || state_q == DRAIN_S) begin
      // Squash everything younger than MEM; MEM/WB keep retiring.
      pcen         = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      ex_mem_flush = 1'b1;
    end else if (sb_if.mem_redirect) begin
      rule_redir   = 1'b1;
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      ex_mem_flush = 1'b1;
    end else if (raw_stall) begin
      rule_stall  = 1'b1;
      pcen        = 1'b0;
      if_id_en    = 1'b0;
      id_ex_flush = 1'b1;
    end else if (sb_if.imem_wait) begin
      pcen        = 1'b0;
      if_id_flush = 1'b1;
    end

    // Drain counter starts at DRAIN-1 on the halt cycle; the last DRAIN_S
    // cycle is the one whose decrement reaches zero.
    case (state_q)
      RUN: begin
        if (sb_if.halt && !sb_if.dmem_wait) begin
          state_d = DRAIN_S;
          drain_d = DW'(DRAIN - 1);
        end
      end
      DRAIN_S: begin
        if (!sb_if.dmem_wait) begin
          if (drain_q <= DW'(1)) begin
            state_d = HALTED;
            drain_d = '0;
          end else begin
            drain_d = drain_q - DW'(1);
          end
        end
      end
      default: state_d = HALTED;
    endcase
  end

  // Only a producer that actually moves into MEM arms its destination counter.
  assign sb_load = ex_mem_en & ~ex_mem_flush & ex_wr & (sb_if.ex_rd != '0);

  always_comb begin
    for (int i = 0; i < NREGS; i++) begin
      logic [LATW-1:0] dec;
      dec      = (cnt_q[i] == '0) ? '0 : (cnt_q[i] - LATW'(1));
      cnt_d[i] = cnt_q[i];
      if (!sb_if.dmem_wait) begin
        cnt_d[i] = dec;
        if (sb_load && (sb_if.ex_rd == REGW'(i)) && (lat_eff >= LATW'(2)) &&
            ((lat_eff - LATW'(2)) > dec))
          cnt_d[i] = lat_eff - LATW'(2);
      end
    end
    stall_d = stall_q + {31'd0, rule_stall};
    flush_d = flush_q + {31'd0, rule_redir};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= RUN;
      drain_q <= '0;
      stall_q <= '0;
      flush_q <= '0;
      for (int i = 0; i < NREGS; i++) cnt_q[i] <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
      for (int i = 0; i < NREGS; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign sb_if.pcen         = pcen;
  assign sb_if.if_id_en     = if_id_en;
  assign sb_if.id_ex_en     = id_ex_en;
  assign sb_if.ex_mem_en    = ex_mem_en;
  assign sb_if.mem_wb_en    = mem_wb_en;
  assign sb_if.if_id_flush  = if_id_flush;
  assign sb_if.id_ex_flush  = id_ex_flush;
  assign sb_if.ex_mem_flush = ex_mem_flush;
  assign sb_if.halted       = halted;
  assign sb_if.stall_cnt    = stall_q;
  assign sb_if.flush_cnt    = flush_q;
endmodule
